// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
// Entry layout is {sel, data}, sel in the upper bits.
package rf_pkg;
  localparam int REG_W    = 16;
  localparam int SEL_W    = 3;
  localparam int NUM_REGS = 1 << SEL_W;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [REG_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small writeback queue with wrap-bit pointers.
// Also exposes per-slot occupancy and key bits for hazard tracking.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 19,
  parameter int KW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      din,
  output logic [W-1:0]      head,
  output logic              full,
  output logic              empty,
  output logic [DEPTH-1:0]  occ,
  output logic [DEPTH*KW-1:0] keys
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic [AW:0]   cnt;
  logic [W-1:0]  mem [DEPTH];

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign cnt   = wp - rp;
  assign head  = mem[rp[AW-1:0]];

  // a slot is live if its distance from the read slot is below the count
  always_comb begin
    occ  = '0;
    keys = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] off;
      off = AW'(i) - rp[AW-1:0];
      occ[i] = ({1'b0, off} < cnt);
      keys[i*KW +: KW] = mem[i][W-1 -: KW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + 1'b1;
      if (pop && !empty)
        rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port
// between the ALU (A) and load (B) writeback queues.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = REG_W,
  parameter int SW    = SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [SW-1:0]     a_regsel,
  input  logic [DW-1:0]     a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [SW-1:0]     b_regsel,
  input  logic [DW-1:0]     b_data,
  output logic              write,
  output logic [SW-1:0]     writeregsel,
  output logic [DW-1:0]     writedata,
  output logic [2**SW-1:0]  busy,
  output logic              err
);
  localparam int EW = SW + DW;

  logic [EW-1:0]       a_head, b_head;
  logic                a_full, a_empty;
  logic                b_full, b_empty;
  logic [DEPTH-1:0]    a_occ, b_occ;
  logic [DEPTH*SW-1:0] a_keys, b_keys;
  logic                grant_a, grant_b;
  logic                rr;
  logic                pa_stall, pb_stall;
  logic [EW-1:0]       pa_pl, pb_pl;

  assign a_ready = !a_full;
  assign b_ready = !b_full;

  wb_fifo #(.DEPTH(DEPTH), .W(EW), .KW(SW)) u_qa (
    .clk   (clk),
    .rst   (rst),
    .push  (a_valid && a_ready),
    .pop   (grant_a),
    .din   ({a_regsel, a_data}),
    .head  (a_head),
    .full  (a_full),
    .empty (a_empty),
    .occ   (a_occ),
    .keys  (a_keys)
  );

  wb_fifo #(.DEPTH(DEPTH), .W(EW), .KW(SW)) u_qb (
    .clk   (clk),
    .rst   (rst),
    .push  (b_valid && b_ready),
    .pop   (grant_b),
    .din   ({b_regsel, b_data}),
    .head  (b_head),
    .full  (b_full),
    .empty (b_empty),
    .occ   (b_occ),
    .keys  (b_keys)
  );

  always_comb begin
    grant_a = !a_empty && (b_empty || rr == SRC_A);
    grant_b = !b_empty && !grant_a;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr          <= SRC_A;
      write       <= 1'b0;
      writeregsel <= '0;
      writedata   <= '0;
    end else begin
      // pointer only moves on contested grants
      if (!a_empty && !b_empty)
        rr <= grant_a ? SRC_B : SRC_A;
      write <= grant_a || grant_b;
      unique case (1'b1)
        grant_a: {writeregsel, writedata} <= a_head;
        grant_b: {writeregsel, writedata} <= b_head;
        default: ;
      endcase
    end
  end

  // a payload change after a refused cycle breaks the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa_stall <= 1'b0;
      pb_stall <= 1'b0;
      pa_pl    <= '0;
      pb_pl    <= '0;
      err      <= 1'b0;
    end else begin
      pa_stall <= a_valid && !a_ready;
      pb_stall <= b_valid && !b_ready;
      pa_pl    <= {a_regsel, a_data};
      pb_pl    <= {b_regsel, b_data};
      if ((pa_stall && a_valid && ({a_regsel, a_data} != pa_pl)) ||
          (pb_stall && b_valid && ({b_regsel, b_data} != pb_pl)))
        err <= 1'b1;
    end
  end

  always_comb begin
    busy = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (a_occ[e])
        busy[a_keys[e*SW +: SW]] = 1'b1;
      if (b_occ[e])
        busy[b_keys[e*SW +: SW]] = 1'b1;
    end
    if (write)
      busy[writeregsel] = 1'b1;
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised bench for rf_write_arbiter against a queue-level model,
// plus directed literal checks for reset, latency, contention and err.
module tb_rf_write_arbiter;
  typedef logic [18:0] ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [2:0]  a_regsel = '0, b_regsel = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        write;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic [7:0]  busy;
  logic        err;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DEPTH(2), .DW(16), .SW(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_regsel(a_regsel), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_regsel(b_regsel), .b_data(b_data),
    .write(write), .writeregsel(writeregsel),
    .writedata(writedata), .busy(busy), .err(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: two plain queues and a favoured-source bit
  ent_t        qa[$], qb[$];
  logic        mrr, mw, merr, pas, pbs;
  logic [2:0]  msel;
  logic [15:0] mdata;
  ent_t        pap, pbp;

  always @(posedge clk or posedge rst) begin
    bit ra, rb, ga, gb;
    ent_t e;
    if (rst) begin
      qa.delete();
      qb.delete();
      mrr <= 1'b0; mw <= 1'b0; merr <= 1'b0;
      msel <= '0; mdata <= '0;
      pas <= 1'b0; pbs <= 1'b0; pap <= '0; pbp <= '0;
    end else begin
      ra = qa.size() < 2;
      rb = qb.size() < 2;
      ga = qa.size() > 0 && (qb.size() == 0 || mrr == 1'b0);
      gb = qb.size() > 0 && !ga;
      if (qa.size() > 0 && qb.size() > 0)
        mrr <= ~mrr;
      mw <= ga || gb;
      if (ga) begin
        e = qa.pop_front();
        msel <= e[18:16]; mdata <= e[15:0];
      end else if (gb) begin
        e = qb.pop_front();
        msel <= e[18:16]; mdata <= e[15:0];
      end
      if (a_valid && ra) qa.push_back({a_regsel, a_data});
      if (b_valid && rb) qb.push_back({b_regsel, b_data});
      if ((pas && a_valid && {a_regsel, a_data} != pap) ||
          (pbs && b_valid && {b_regsel, b_data} != pbp))
        merr <= 1'b1;
      pas <= a_valid && !ra;
      pbs <= b_valid && !rb;
      pap <= {a_regsel, a_data};
      pbp <= {b_regsel, b_data};
    end
  end

  function automatic logic [7:0] mbusy();
    logic [7:0] b = '0;
    foreach (qa[i]) b[qa[i][18:16]] = 1'b1;
    foreach (qb[i]) b[qb[i][18:16]] = 1'b1;
    if (mw) b[msel] = 1'b1;
    return b;
  endfunction

  bit   sa, sb;
  ent_t wlog[$];

  // one clock: compare against the model mid-cycle, then advance
  task automatic cyc();
    @(negedge clk);
    sa = a_valid && !a_ready;
    sb = b_valid && !b_ready;
    if (!rst) begin
      chk("a_ready", 32'(a_ready), 32'(qa.size() < 2));
      chk("b_ready", 32'(b_ready), 32'(qb.size() < 2));
      chk("write", 32'(write), 32'(mw));
      chk("busy", 32'(busy), 32'(mbusy()));
      chk("err", 32'(err), 32'(merr));
      if (mw) begin
        chk("writeregsel", 32'(writeregsel), 32'(msel));
        chk("writedata", 32'(writedata), 32'(mdata));
      end
      if (write) wlog.push_back({writeregsel, writedata});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit flag;
    ent_t exp_e;

    cyc(); cyc();
    rst = 1'b0;
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_busy", 32'(busy), 32'h00);

    // single write latency
    a_valid = 1'b1; a_regsel = 3'd3; a_data = 16'hBEEF;
    cyc();
    a_valid = 1'b0;
    chk("sw_busy_e0", 32'(busy), 32'h08);
    chk("sw_write_e0", 32'(write), 32'd0);
    cyc();
    chk("sw_write_e1", 32'(write), 32'd1);
    chk("sw_sel_e1", 32'(writeregsel), 32'd3);
    chk("sw_data_e1", 32'(writedata), 32'hBEEF);
    chk("sw_busy_e1", 32'(busy), 32'h08);
    cyc();
    chk("sw_busy_e2", 32'(busy), 32'h00);
    chk("sw_write_e2", 32'(write), 32'd0);

    // asynchronous reset mid-cycle with work pending
    a_valid = 1'b1; a_regsel = 3'd5; a_data = 16'h0505;
    b_valid = 1'b1; b_regsel = 3'd6; b_data = 16'h0606;
    cyc(); cyc();
    #3;
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("mid_rst_write", 32'(write), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'h00);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_a_ready", 32'(a_ready), 32'd1);
    chk("mid_rst_b_ready", 32'(b_ready), 32'd1);

    // contention: grants alternate starting with A
    a_valid = 1'b1; a_regsel = 3'd1; a_data = 16'h1111;
    b_valid = 1'b1; b_regsel = 3'd2; b_data = 16'h2222;
    flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (!a_ready) flag = 1'b1;
      if (i >= 1) begin
        chk("ct_write", 32'(write), 32'd1);
        chk("ct_sel", 32'(writeregsel), (i % 2 == 1) ? 32'd1 : 32'd2);
      end
    end
    chk("ct_a_full", 32'(flag), 32'd1);

    // back-pressure release once B stops competing
    b_valid = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 10 && !flag; i++) begin
      cyc();
      if (a_ready) flag = 1'b1;
    end
    chk("bp_a_ready_back", 32'(flag), 32'd1);
    a_valid = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 20 && !flag; i++) begin
      cyc();
      if (busy == 8'h00 && !write) flag = 1'b1;
    end
    chk("bp_drained", 32'(flag), 32'd1);

    // pointer wrap: five pushes through A, issue order kept
    wlog.delete();
    for (int k = 0; k < 5; k++) begin
      a_valid = 1'b1; a_regsel = 3'(k); a_data = 16'hC0D0 + 16'(k);
      cyc();
      a_valid = 1'b0;
      cyc();
    end
    repeat (3) cyc();
    chk("wrap_count", 32'(wlog.size()), 32'd5);
    for (int k = 0; k < 5 && k < wlog.size(); k++) begin
      exp_e = {3'(k), 16'hC0D0 + 16'(k)};
      chk("wrap_order", 32'(wlog[k]), 32'(exp_e));
    end

    // randomised traffic honouring the stall rule
    for (int n = 0; n < 400; n++) begin
      if (!sa) begin
        a_valid = 1'($urandom_range(0, 1));
        a_regsel = 3'($urandom);
        a_data = 16'($urandom);
      end
      if (!sb) begin
        b_valid = 1'($urandom_range(0, 1));
        b_regsel = 3'($urandom);
        b_data = 16'($urandom);
      end
      cyc();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (6) cyc();
    chk("rand_no_err", 32'(err), 32'd0);

    // protocol error: payload change while refused
    a_valid = 1'b1; a_regsel = 3'd4; a_data = 16'h1234;
    b_valid = 1'b1; b_regsel = 3'd5; b_data = 16'h5678;
    flag = 1'b0;
    for (int i = 0; i < 10 && !flag; i++) begin
      cyc();
      if (!a_ready) flag = 1'b1;
    end
    chk("err_a_stalled", 32'(flag), 32'd1);
    cyc();
    a_data = 16'h4321;
    cyc();
    chk("err_set", 32'(err), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (4) cyc();
    chk("err_sticky", 32'(err), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("err_rst", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc();
    chk("err_after_rst", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
